lsu_ctrl: RTL and testbench

Load/store sequencer between the decode/control stage and the data memory port. It accepts a decoded load or store (`load_i`/`store_i`, `sx_size_i`, ALU-computed address, store data, `rd_i`) and issues one word-aligned request with byte enables. It holds the core stalled until the memory acknowledges. For loads it returns the sign- or zero-extended result one cycle later, together with `delayed_load_o`/`delayed_rd_o`, for register write-back.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_ctrl.sv | 130 +++++++++++++
 tb/tb_lsu_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and lane helpers for lsu_ctrl
package lsu_pkg;

  localparam logic [2:0] SX_B  = 3'b000;
  localparam logic [2:0] SX_BU = 3'b001;
  localparam logic [2:0] SX_H  = 3'b010;
  localparam logic [2:0] SX_HU = 3'b011;
  localparam logic [2:0] SX_W  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lsu_state_t;

  function automatic logic lsu_is_byte(input logic [2:0] size);
    return (size == SX_B) || (size == SX_BU);
  endfunction

  function automatic logic lsu_is_half(input logic [2:0] size);
    return (size == SX_H) || (size == SX_HU);
  endfunction

  // Unlisted size codes fall through to the word rules.
  function automatic logic lsu_aligned(input logic [2:0] size, input logic [1:0] off);
    if (lsu_is_byte(size)) return 1'b1;
    if (lsu_is_half(size)) return ~off[0];
    return off == 2'b00;
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    if (lsu_is_byte(size)) return 4'b0001 << off;
    if (lsu_is_half(size)) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lsu_wrep(input logic [2:0] size, input logic [31:0] wdata);
    if (lsu_is_byte(size)) return {4{wdata[7:0]}};
    if (lsu_is_half(size)) return {2{wdata[15:0]}};
    return wdata;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts the addressed lane of a read word and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (offset)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      SX_B:    data = {{24{w_byte[7]}}, w_byte};
      SX_BU:   data = {24'h0, w_byte};
      SX_H:    data = {{16{w_half[15]}}, w_half};
      SX_HU:   data = {16'h0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: one aligned memory request per access, stall until ack
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        sx_size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              stall_o,
  output logic              delayed_load_o,
  output logic [4:0]        delayed_rd_o,
  output logic [31:0]       load_data_o,
  output logic              misalign_o
);

  lsu_state_t        r_state;
  logic [1:0]        r_off;
  logic [2:0]        r_size;
  logic [4:0]        r_rd;
  logic              r_we;
  logic              r_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_dload;
  logic [4:0]        r_drd;
  logic [31:0]       r_ldata;

  logic              w_access;
  logic              w_aligned;
  logic              w_accept;
  logic [31:0]       w_ext;

  assign w_access  = load_i | store_i;
  assign w_aligned = lsu_aligned(sx_size_i, addr_i[1:0]);
  assign w_accept  = (r_state == ST_IDLE) && w_access && w_aligned;

  lsu_load_align u_align (
    .rdata  (mem_rdata_i),
    .offset (r_off),
    .size   (r_size),
    .data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_off    <= 2'b00;
      r_size   <= 3'b000;
      r_rd     <= 5'd0;
      r_we     <= 1'b0;
      r_req    <= 1'b0;
      r_mem_we <= 1'b0;
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'h0;
      r_dload  <= 1'b0;
      r_drd    <= 5'd0;
      r_ldata  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_off    <= addr_i[1:0];
            r_size   <= sx_size_i;
            r_rd     <= rd_i;
            r_we     <= store_i;
            r_req    <= 1'b1;
            r_mem_we <= store_i;
            r_addr   <= {addr_i[ADDR_W-1:2], 2'b00};
            r_be     <= lsu_be(sx_size_i, addr_i[1:0]);
            r_wdata  <= lsu_wrep(sx_size_i, wdata_i);
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request fields stay frozen until the ack, then the port is released.
          if (mem_ack_i) begin
            r_req    <= 1'b0;
            r_mem_we <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'b0000;
            r_wdata  <= 32'h0;
            if (r_we) begin
              r_state <= ST_IDLE;
            end else begin
              r_ldata <= w_ext;
              r_dload <= 1'b1;
              r_drd   <= r_rd;
              r_state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          r_dload <= 1'b0;
          r_drd   <= 5'd0;
          r_ldata <= 32'h0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_o      = r_req;
  assign mem_we_o       = r_mem_we;
  assign mem_addr_o     = r_addr;
  assign mem_be_o       = r_be;
  assign mem_wdata_o    = r_wdata;
  assign delayed_load_o = r_dload;
  assign delayed_rd_o   = r_drd;
  assign load_data_o    = r_ldata;
  assign misalign_o     = (r_state == ST_IDLE) && w_access && !w_aligned;
  assign stall_o        = w_accept || (r_state == ST_REQ);

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized and directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_i, store_i;
  logic [2:0]        sx_size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [4:0]        rd_i;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;
  logic              stall_o, delayed_load_o, misalign_o;
  logic [4:0]        delayed_rd_o;
  logic [31:0]       load_data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        misalign;
    logic        stall_acc;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stable;
    int          stalls;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } obs_t;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_i),
    .store_i        (store_i),
    .sx_size_i      (sx_size_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rd_i           (rd_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .stall_o        (stall_o),
    .delayed_load_o (delayed_load_o),
    .delayed_rd_o   (delayed_rd_o),
    .load_data_o    (load_data_o),
    .misalign_o     (misalign_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_bytes(input logic [2:0] size);
    if (size <= 3'd1) return 1;
    if (size <= 3'd3) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] size);
    logic [31:0] v;
    int off;
    off = int'(addr[1:0]);
    case (size)
      3'd0, 3'd1: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (size == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'd2, 3'd3: begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (size == 3'd2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [2:0] size);
    int n;
    n = ref_bytes(size);
    return 4'(((1 << n) - 1) << (int'(addr[1:0]) / n * n));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wdata, input logic [2:0] size);
    int n;
    n = ref_bytes(size);
    if (n == 1) return (wdata & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  task automatic do_access(input logic ld, input logic st, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input int waits, output obs_t o);
    load_i = ld; store_i = st; sx_size_i = size; addr_i = addr; wdata_i = wdata; rd_i = rd;
    #1;
    o.misalign  = misalign_o;
    o.stall_acc = stall_o;
    o.stalls    = stall_o ? 1 : 0;
    tick();
    load_i = 1'b0; store_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom);
    o.req = mem_req_o; o.we = mem_we_o; o.addr = mem_addr_o; o.be = mem_be_o; o.wdata = mem_wdata_o;
    o.stable = 1'b1;
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
      end
      if (mem_req_o !== o.req || mem_we_o !== o.we || mem_addr_o !== o.addr ||
          mem_be_o !== o.be || mem_wdata_o !== o.wdata) o.stable = 1'b0;
      if (stall_o) o.stalls++;
      tick();
    end
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    o.wb = delayed_load_o; o.rd = delayed_rd_o; o.data = load_data_o;
    if (stall_o) o.stalls++;
    tick();
    addr_i = '0; wdata_i = '0; rd_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
    n_cmp++; if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin n_fail++;
      $display("FAIL reset_mem got we=%b a=%h be=%b wd=%h exp 0", mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o); end
    n_cmp++; if ({delayed_load_o, delayed_rd_o, load_data_o} !== '0) begin n_fail++;
      $display("FAIL reset_wb got dl=%b rd=%0d ld=%h exp 0", delayed_load_o, delayed_rd_o, load_data_o); end
    n_cmp++; if ({stall_o, misalign_o} !== 2'b00) begin n_fail++;
      $display("FAIL reset_stall got stall=%b mis=%b exp 0", stall_o, misalign_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_case(input string nm, input logic ld, input logic st, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rdata, input int waits);
    obs_t o;
    logic exp_wb;
    do_access(ld, st, size, addr, wdata, rd, rdata, waits, o);
    exp_wb = ld & ~st;
    n_cmp++; if (o.misalign !== 1'b0 || o.stall_acc !== 1'b1) begin n_fail++;
      $display("FAIL %s_accept got mis=%b stall=%b exp 0/1", nm, o.misalign, o.stall_acc); end
    n_cmp++; if (o.req !== 1'b1 || o.we !== st) begin n_fail++;
      $display("FAIL %s_req got req=%b we=%b exp 1/%b", nm, o.req, o.we, st); end
    n_cmp++; if (o.addr !== (addr & ~32'h3)) begin n_fail++;
      $display("FAIL %s_addr got %h exp %h", nm, o.addr, addr & ~32'h3); end
    n_cmp++; if (o.be !== ref_be(addr, size)) begin n_fail++;
      $display("FAIL %s_be got %b exp %b", nm, o.be, ref_be(addr, size)); end
    if (st) begin
      n_cmp++; if (o.wdata !== ref_wdata(wdata, size)) begin n_fail++;
        $display("FAIL %s_wdata got %h exp %h", nm, o.wdata, ref_wdata(wdata, size)); end
    end
    n_cmp++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL %s_stable got 0 exp 1", nm); end
    n_cmp++; if (o.stalls != waits + 2) begin n_fail++;
      $display("FAIL %s_stalls got %0d exp %0d", nm, o.stalls, waits + 2); end
    n_cmp++; if (o.wb !== exp_wb || o.rd !== (exp_wb ? rd : 5'd0)) begin n_fail++;
      $display("FAIL %s_wb got dl=%b rd=%0d exp %b/%0d", nm, o.wb, o.rd, exp_wb, exp_wb ? rd : 5'd0); end
    n_cmp++; if (o.data !== (exp_wb ? ref_load(rdata, addr, size) : 32'h0)) begin n_fail++;
      $display("FAIL %s_data got %h exp %h", nm, o.data, exp_wb ? ref_load(rdata, addr, size) : 32'h0); end
  endtask

  task automatic test_directed();
    check_case("ld_s8",    1'b1, 1'b0, 3'b000, 32'h1003, 32'h0,         5'd7,  32'h80AA_BBCC, 0);
    check_case("ld_u16",   1'b1, 1'b0, 3'b011, 32'h2002, 32'h0,         5'd9,  32'h9234_5678, 0);
    check_case("st_b",     1'b0, 1'b1, 3'b000, 32'h3001, 32'h0000_00A5, 5'd0,  32'h0,         0);
    check_case("ld_w_wait",1'b1, 1'b0, 3'b100, 32'h5000, 32'h0,         5'd31, 32'hDEAD_BEEF, 2);
    check_case("ldst_h",   1'b1, 1'b1, 3'b010, 32'h6002, 32'h1234_ABCD, 5'd3,  32'h0,         1);
    check_case("ld_odd",   1'b1, 1'b0, 3'b111, 32'h7004, 32'h0,         5'd12, 32'h8765_4321, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  size;
      logic [31:0] addr;
      int sel;
      size = 3'($urandom_range(0, 7));
      addr = $urandom & ~(32'(ref_bytes(size)) - 32'd1);
      sel  = $urandom_range(0, 2);
      check_case("rand", sel != 1, sel != 0, size, addr, $urandom, 5'($urandom), $urandom,
                 $urandom_range(0, 3));
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2] = '{32'h4002, 32'h4001};
    logic [2:0]  sizes [2] = '{3'b100, 3'b010};
    for (int i = 0; i < 2; i++) begin
      load_i = (i == 0); store_i = (i == 1); sx_size_i = sizes[i]; addr_i = addrs[i];
      #1;
      n_cmp++; if (misalign_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++;
        $display("FAIL misalign_%0d got mis=%b stall=%b exp 1/0", i, misalign_o, stall_o); end
      tick();
      n_cmp++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++;
        $display("FAIL misalign_noreq_%0d got req=%b stall=%b exp 0/0", i, mem_req_o, stall_o); end
      load_i = 1'b0; store_i = 1'b0; addr_i = '0;
      tick();
    end
  endtask

  task automatic test_reset_in_req();
    load_i = 1'b1; sx_size_i = 3'b100; addr_i = 32'h8000; rd_i = 5'd5;
    tick();
    load_i = 1'b0;
    n_cmp++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre got %b exp 1", mem_req_o); end
    rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    rst = 1'b0; mem_ack_i = 1'b0;
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, stall_o} !== '0) begin n_fail++;
      $display("FAIL rst_req_out got req=%b a=%h be=%b stall=%b exp 0", mem_req_o, mem_addr_o, mem_be_o, stall_o); end
    n_cmp++; if ({delayed_load_o, delayed_rd_o, load_data_o} !== '0) begin n_fail++;
      $display("FAIL rst_req_wb got dl=%b rd=%0d ld=%h exp 0", delayed_load_o, delayed_rd_o, load_data_o); end
    tick();
    n_cmp++; if (delayed_load_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_wb2 got %b exp 0", delayed_load_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if ({mem_req_o, delayed_load_o, load_data_o, stall_o} !== '0) begin n_fail++;
      $display("FAIL spurious_ack got req=%b dl=%b ld=%h stall=%b exp 0", mem_req_o, delayed_load_o, load_data_o, stall_o); end
    tick();
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; store_i = 1'b0; sx_size_i = 3'b000; addr_i = '0;
    wdata_i = '0; rd_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    #2;
    test_reset();
    test_directed();
    test_misalign();
    test_reset_in_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
